// File: rtl/event_framer_pkg.sv
// Shared types and frame layout for the event framer: FSM state encoding,
// header/trailer magic words and field positions inside a 64-bit frame word.
package event_framer_pkg;

    localparam int TDATA_WIDTH = 64;

    localparam logic [15:0] HEADER_MAGIC  = 16'hEB90;
    localparam logic [15:0] TRAILER_MAGIC = 16'h90EB;

    // Field positions: magic in the top 16 bits of both words, the sequence
    // number in the low 32 bits of the header, the truncation flag at bit 32
    // and the payload word count in the low 16 bits of the trailer.
    localparam int MAGIC_LSB     = 48;
    localparam int HDR_SEQ_LSB   = 0;
    localparam int TRL_TRUNC_BIT = 32;
    localparam int TRL_CNT_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_TRAILER = 3'd4
    } state_t;

    function automatic logic [TDATA_WIDTH-1:0] make_header(input logic [31:0] seq);
        logic [TDATA_WIDTH-1:0] w;
        w = '0;
        w[MAGIC_LSB +: 16]   = HEADER_MAGIC;
        w[HDR_SEQ_LSB +: 32] = seq;
        return w;
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] make_trailer(input logic trunc,
                                                             input logic [15:0] cnt);
        logic [TDATA_WIDTH-1:0] w;
        w = '0;
        w[MAGIC_LSB +: 16]   = TRAILER_MAGIC;
        w[TRL_TRUNC_BIT]     = trunc;
        w[TRL_CNT_LSB +: 16] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/event_framer_if.sv
// AXI-Stream style bundle used for both the trigger-side and DMA-side streams.
// A word transfers on a clock edge where TVALID and TREADY are both high; the
// source holds TDATA/TLAST/TUSER stable and keeps TVALID high until then.
interface event_framer_if;
    import event_framer_pkg::*;

    logic [TDATA_WIDTH-1:0] TDATA;
    logic                   TVALID;
    logic                   TREADY;
    logic                   TLAST;
    logic                   TUSER;

    modport master (output TDATA, output TVALID, output TLAST, output TUSER, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, input TUSER, output TREADY);

endinterface

// File: rtl/event_framer.sv
// Wraps each input event in a sequence-numbered header and a count/truncation
// trailer, cutting events longer than MAX_PAYLOAD_WORDS and draining the rest.
module event_framer
    import event_framer_pkg::*;
#(
    parameter int MAX_PAYLOAD_WORDS = 128
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    event_framer_if.slave         S_AXIS,
    event_framer_if.master        M_AXIS,
    output logic [31:0]           O_EVENT_COUNT,
    output logic                  O_TRUNC_FLAG,
    output state_t                O_DBG_STATE
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_PAYLOAD_WORDS);

    state_t      r_state;
    logic [31:0] r_seq;
    logic [15:0] r_word_cnt;
    logic        r_trunc;
    logic        r_trunc_sticky;

    state_t                 w_state_nxt;
    logic [31:0]            w_seq_nxt;
    logic [15:0]            w_word_cnt_nxt;
    logic [15:0]            w_cnt_inc;
    logic                   w_trunc_nxt;
    logic                   w_trunc_sticky_nxt;
    logic                   w_s_tready;
    logic                   w_m_tvalid;
    logic [TDATA_WIDTH-1:0] w_m_tdata;
    logic                   w_m_tlast;
    logic                   w_m_tuser;
    logic                   w_unused_tuser;

    // The input time-stamp marker plays no part in framing.
    assign w_unused_tuser = S_AXIS.TUSER;
    assign w_cnt_inc      = r_word_cnt + 16'd1;

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            r_state        <= ST_IDLE;
            r_seq          <= '0;
            r_word_cnt     <= '0;
            r_trunc        <= 1'b0;
            r_trunc_sticky <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_seq          <= w_seq_nxt;
            r_word_cnt     <= w_word_cnt_nxt;
            r_trunc        <= w_trunc_nxt;
            r_trunc_sticky <= w_trunc_sticky_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_seq_nxt          = r_seq;
        w_word_cnt_nxt     = r_word_cnt;
        w_trunc_nxt        = r_trunc;
        w_trunc_sticky_nxt = r_trunc_sticky;
        w_s_tready         = 1'b0;
        w_m_tvalid         = 1'b0;
        w_m_tdata          = '0;
        w_m_tlast          = 1'b0;
        w_m_tuser          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Only peek at TVALID; the first word stays on the bus.
                if (S_AXIS.TVALID) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                w_m_tvalid = 1'b1;
                w_m_tuser  = 1'b1;
                w_m_tdata  = make_header(r_seq);
                if (M_AXIS.TREADY) begin
                    w_word_cnt_nxt = '0;
                    w_trunc_nxt    = 1'b0;
                    w_state_nxt    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                w_m_tdata  = S_AXIS.TDATA;
                w_m_tvalid = S_AXIS.TVALID;
                w_s_tready = M_AXIS.TREADY;
                if (S_AXIS.TVALID && M_AXIS.TREADY) begin
                    w_word_cnt_nxt = w_cnt_inc;
                    // TLAST on the limit word is a normal end, so it wins.
                    if (S_AXIS.TLAST) begin
                        w_trunc_nxt = 1'b0;
                        w_state_nxt = ST_TRAILER;
                    end else if (w_cnt_inc == MAX_CNT) begin
                        w_trunc_nxt        = 1'b1;
                        w_trunc_sticky_nxt = 1'b1;
                        w_state_nxt        = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_s_tready = 1'b1;
                if (S_AXIS.TVALID && S_AXIS.TLAST) begin
                    w_state_nxt = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                w_m_tvalid = 1'b1;
                w_m_tlast  = 1'b1;
                w_m_tdata  = make_trailer(r_trunc, r_word_cnt);
                if (M_AXIS.TREADY) begin
                    w_seq_nxt   = r_seq + 32'd1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign S_AXIS.TREADY = w_s_tready;
    assign M_AXIS.TVALID = w_m_tvalid;
    assign M_AXIS.TDATA  = w_m_tdata;
    assign M_AXIS.TLAST  = w_m_tlast;
    assign M_AXIS.TUSER  = w_m_tuser;

    assign O_EVENT_COUNT = r_seq;
    assign O_TRUNC_FLAG  = r_trunc_sticky;
    assign O_DBG_STATE   = r_state;

endmodule

// File: tb/tb_event_framer.sv
// Directed bench for event_framer: inputs change on the falling edge, outputs
// are sampled shortly after it, and output beats are collected for comparison.
module tb_event_framer;
    import event_framer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] event_count;
    logic        trunc_flag;
    state_t      dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [65:0] exp_q[$];
    logic [65:0] obs_q[$];

    event_framer_if s_if();
    event_framer_if m_if();

    event_framer #(.MAX_PAYLOAD_WORDS(128)) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (rst_n),
        .S_AXIS       (s_if),
        .M_AXIS       (m_if),
        .O_EVENT_COUNT(event_count),
        .O_TRUNC_FLAG (trunc_flag),
        .O_DBG_STATE  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output beat collector: {TLAST, TUSER, TDATA} of every accepted beat
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && m_if.TVALID && m_if.TREADY)
                obs_q.push_back({m_if.TLAST, m_if.TUSER, m_if.TDATA});
        end
    end

    // Driver: sends an n-word event (word i = base + i) with TREADY held high
    task automatic run_frame(input int n, input logic [63:0] base,
                             output int cyc, output bit done);
        int idx;
        idx  = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < n + 100) begin
            @(negedge clk);
            m_if.TREADY = 1'b1;
            if (idx < n) begin
                s_if.TVALID = 1'b1;
                s_if.TDATA  = base + 64'(idx);
                s_if.TLAST  = (idx == n - 1);
            end else begin
                s_if.TVALID = 1'b0;
                s_if.TDATA  = '0;
                s_if.TLAST  = 1'b0;
            end
            #1;
            if (s_if.TVALID && s_if.TREADY) idx++;
            if (m_if.TVALID && m_if.TREADY && m_if.TLAST) done = 1'b1;
            cyc++;
        end
        @(negedge clk);
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
        s_if.TDATA  = '0;
        #3;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        s_if.TLAST  = 1'b0;
        s_if.TUSER  = 1'b0;
        m_if.TREADY = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (s_if.TREADY !== 1'b0) begin failures++; $display("FAIL reset_s_tready: got %b want 0", s_if.TREADY); end
        checks++; if (m_if.TVALID !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid: got %b want 0", m_if.TVALID); end
        checks++; if (m_if.TLAST !== 1'b0) begin failures++; $display("FAIL reset_m_tlast: got %b want 0", m_if.TLAST); end
        checks++; if (m_if.TUSER !== 1'b0) begin failures++; $display("FAIL reset_m_tuser: got %b want 0", m_if.TUSER); end
        checks++; if (m_if.TDATA !== 64'h0) begin failures++; $display("FAIL reset_m_tdata: got %h want 0", m_if.TDATA); end
        checks++; if (event_count !== 32'h0) begin failures++; $display("FAIL reset_count: got %0d want 0", event_count); end
        checks++; if (trunc_flag !== 1'b0) begin failures++; $display("FAIL reset_trunc: got %b want 0", trunc_flag); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_basic();
        int cyc;
        bit done;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_0000_0000});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, 64'hD000_0000_0000_0000 + 64'(i)});
        exp_q.push_back({2'b10, 64'h90EB_0000_0000_0004});
        run_frame(4, 64'hD000_0000_0000_0000, cyc, done);
        checks++; if (!done) begin failures++; $display("FAIL basic_timeout: trailer not seen within budget"); end
        checks++; if (cyc !== 7) begin failures++; $display("FAIL basic_cycles: got %0d want 7", cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL basic_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'd1) begin failures++; $display("FAIL basic_count: got %0d want 1", event_count); end
        checks++; if (trunc_flag !== 1'b0) begin failures++; $display("FAIL basic_trunc: got %b want 0", trunc_flag); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit done;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_0000_0001});
        exp_q.push_back({2'b00, 64'h1234_5678_9ABC_DEF0});
        exp_q.push_back({2'b10, 64'h90EB_0000_0000_0001});
        run_frame(1, 64'h1234_5678_9ABC_DEF0, cyc, done);
        checks++; if (!done) begin failures++; $display("FAIL b2b_timeout: trailer not seen within budget"); end
        checks++; if (cyc !== 4) begin failures++; $display("FAIL b2b_cycles: got %0d want 4", cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'd2) begin failures++; $display("FAIL b2b_count: got %0d want 2", event_count); end
    endtask

    task automatic test_exact_max();
        int cyc;
        bit done;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_0000_0002});
        for (int i = 0; i < 128; i++) exp_q.push_back({2'b00, 64'hAA00_0000_0000_0000 + 64'(i)});
        exp_q.push_back({2'b10, 64'h90EB_0000_0000_0080});
        run_frame(128, 64'hAA00_0000_0000_0000, cyc, done);
        checks++; if (!done) begin failures++; $display("FAIL exact_timeout: trailer not seen within budget"); end
        checks++; if (cyc !== 131) begin failures++; $display("FAIL exact_cycles: got %0d want 131", cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL exact_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL exact_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'd3) begin failures++; $display("FAIL exact_count: got %0d want 3", event_count); end
        checks++; if (trunc_flag !== 1'b0) begin failures++; $display("FAIL exact_trunc: got %b want 0", trunc_flag); end
    endtask

    task automatic test_truncate();
        int cyc;
        bit done;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_0000_0003});
        for (int i = 0; i < 128; i++) exp_q.push_back({2'b00, 64'hBB00_0000_0000_0000 + 64'(i)});
        exp_q.push_back({2'b10, 64'h90EB_0001_0000_0080});
        run_frame(200, 64'hBB00_0000_0000_0000, cyc, done);
        checks++; if (!done) begin failures++; $display("FAIL trunc_timeout: trailer not seen within budget"); end
        // 1 idle + 1 header + 128 payload + 72 drain + 1 trailer
        checks++; if (cyc !== 203) begin failures++; $display("FAIL trunc_cycles: got %0d want 203", cyc); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL trunc_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'd4) begin failures++; $display("FAIL trunc_count: got %0d want 4", event_count); end
        checks++; if (trunc_flag !== 1'b1) begin failures++; $display("FAIL trunc_flag: got %b want 1", trunc_flag); end
    endtask

    task automatic test_backpressure();
        int          idx;
        int          cyc;
        bit          done;
        bit          prev_stall;
        logic [65:0] prev_beat;
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_0000_0004});
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 64'hCC00_0000_0000_0010 + 64'(i)});
        exp_q.push_back({2'b10, 64'h90EB_0000_0000_0003});
        idx        = 0;
        cyc        = 0;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_beat  = '0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            m_if.TREADY = (cyc % 2 == 0);
            if (idx < 3) begin
                s_if.TVALID = 1'b1;
                s_if.TDATA  = 64'hCC00_0000_0000_0010 + 64'(idx);
                s_if.TLAST  = (idx == 2);
            end else begin
                s_if.TVALID = 1'b0;
                s_if.TDATA  = '0;
                s_if.TLAST  = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (m_if.TVALID !== 1'b1 || {m_if.TLAST, m_if.TUSER, m_if.TDATA} !== prev_beat) begin
                    failures++;
                    $display("FAIL bp_hold_cyc%0d: got valid=%b beat=%h want valid=1 beat=%h",
                             cyc, m_if.TVALID, {m_if.TLAST, m_if.TUSER, m_if.TDATA}, prev_beat);
                end
            end
            if (dbg_state == ST_PAYLOAD) begin
                checks++;
                if (s_if.TREADY !== m_if.TREADY) begin failures++; $display("FAIL bp_tready_cyc%0d: got %b want %b", cyc, s_if.TREADY, m_if.TREADY); end
            end
            prev_stall = m_if.TVALID && !m_if.TREADY;
            prev_beat  = {m_if.TLAST, m_if.TUSER, m_if.TDATA};
            if (s_if.TVALID && s_if.TREADY) idx++;
            if (m_if.TVALID && m_if.TREADY && m_if.TLAST) done = 1'b1;
            cyc++;
        end
        @(negedge clk);
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
        m_if.TREADY = 1'b1;
        #3;
        checks++; if (!done) begin failures++; $display("FAIL bp_timeout: trailer not seen within budget"); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL bp_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'd5) begin failures++; $display("FAIL bp_count: got %0d want 5", event_count); end
    endtask

    task automatic test_seq_wrap();
        int cyc;
        bit done;
        @(negedge clk);
        force dut.r_seq = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_seq;
        @(negedge clk);
        #1;
        checks++; if (event_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload: got %h want ffffffff", event_count); end
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_FFFF_FFFF});
        exp_q.push_back({2'b00, 64'h5555_0000_0000_0001});
        exp_q.push_back({2'b10, 64'h90EB_0000_0000_0001});
        run_frame(1, 64'h5555_0000_0000_0001, cyc, done);
        checks++; if (!done) begin failures++; $display("FAIL wrap_timeout: trailer not seen within budget"); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL wrap_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'h0) begin failures++; $display("FAIL wrap_count: got %h want 0", event_count); end
        checks++; if (trunc_flag !== 1'b1) begin failures++; $display("FAIL wrap_trunc_sticky: got %b want 1", trunc_flag); end
    endtask

    task automatic test_reset_mid();
        int idx;
        int cyc;
        bit done;
        idx = 0;
        cyc = 0;
        while (idx < 2 && cyc < 50) begin
            @(negedge clk);
            m_if.TREADY = 1'b1;
            s_if.TVALID = 1'b1;
            s_if.TDATA  = 64'hEE00_0000_0000_0000 + 64'(idx);
            s_if.TLAST  = 1'b0;
            #1;
            if (s_if.TVALID && s_if.TREADY) idx++;
            cyc++;
        end
        checks++; if (idx !== 2) begin failures++; $display("FAIL rmid_setup: accepted %0d words want 2", idx); end
        @(negedge clk);
        checks++; if (dbg_state !== ST_PAYLOAD) begin failures++; $display("FAIL rmid_state_before: got %0d want %0d", dbg_state, ST_PAYLOAD); end
        rst_n       = 1'b0;
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, ST_IDLE); end
        checks++; if (s_if.TREADY !== 1'b0 || m_if.TVALID !== 1'b0 || m_if.TLAST !== 1'b0 || m_if.TUSER !== 1'b0) begin
            failures++;
            $display("FAIL rmid_ctrl: got s_tready=%b m_tvalid=%b tlast=%b tuser=%b want all 0",
                     s_if.TREADY, m_if.TVALID, m_if.TLAST, m_if.TUSER);
        end
        checks++; if (m_if.TDATA !== 64'h0) begin failures++; $display("FAIL rmid_tdata: got %h want 0", m_if.TDATA); end
        checks++; if (event_count !== 32'h0) begin failures++; $display("FAIL rmid_count: got %0d want 0", event_count); end
        checks++; if (trunc_flag !== 1'b0) begin failures++; $display("FAIL rmid_trunc: got %b want 0", trunc_flag); end
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back({2'b01, 64'hEB90_0000_0000_0000});
        for (int i = 0; i < 2; i++) exp_q.push_back({2'b00, 64'hF000_0000_0000_0000 + 64'(i)});
        exp_q.push_back({2'b10, 64'h90EB_0000_0000_0002});
        run_frame(2, 64'hF000_0000_0000_0000, cyc, done);
        checks++; if (!done) begin failures++; $display("FAIL rmid_timeout: trailer not seen within budget"); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rmid_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (event_count !== 32'd1) begin failures++; $display("FAIL rmid_count_after: got %0d want 1", event_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_exact_max();
        test_truncate();
        test_backpressure();
        test_seq_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
